// File: rtl/prio_arbiter_pkg.sv
// prio_arbiter_pkg
//   Shared definitions for the 4-way priority arbiter: requester count,
//   index width, hold-counter width, FSM state encoding and a one-hot helper.
package prio_arbiter_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_arbiter_rr_pick.sv
// rr_pick
//   Combinational winner selection for the arbiter.
//   Ports:
//     req   in  N_REQ  request vector
//     ptr   in  IDX_W  rotating start index (ignored when rr_en=0)
//     rr_en in  1      1 = search upward from ptr with wrap, 0 = lowest index wins
//     idx   out IDX_W  winning index (0 when no request)
//     any   out 1      at least one request present
module rr_pick
    import prio_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_en,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        base = rr_en ? ptr : '0;
        // cand is IDX_W wide, so base + i wraps 3 -> 0 on its own.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = base + IDX_W'(i);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter
//   4-requester arbiter with rotating or fixed priority, bounded grant hold
//   time and a one-cycle release gap. Every output is a flop.
//   Parameters:
//     MAX_HOLD  maximum consecutive grant cycles (1..15)
//     RR_EN     1 = rotating priority, 0 = fixed priority (index 0 highest)
//   Ports:
//     clock      in  1      rising-edge clock
//     reset      in  1      asynchronous active-low reset
//     enable     in  1      allows new grants from IDLE
//     req        in  4      level-sensitive requests
//     gnt        out 4      one-hot grant or zero
//     gnt_idx    out 2      binary index of the granted requester
//     gnt_valid  out 1      OR of gnt
//     done       out 1      one-cycle pulse per grant release
//     busy       out 1      high whenever the arbiter is not IDLE
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned RR_EN    = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             done,
    output logic             busy
);

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              release_now;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .rr_en (RR_EN != 0),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A dropped request and a hold timeout on the same edge still give a
    // single release, since both feed one condition.
    assign release_now = !req[gnt_idx] || (hold_cnt == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (enable && pick_any) begin
                        state     <= GRANT;
                        gnt       <= idx_to_onehot(pick_idx);
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        busy      <= 1'b1;
                        hold_cnt  <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= GAP;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        done      <= 1'b1;
                        ptr       <= gnt_idx + IDX_W'(1);
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter
//   Four arbiter instances share one set of inputs, each with different
//   parameters: d0 fixed/MAX_HOLD=8, d1 rotating/2, d2 rotating/8,
//   d3 rotating/1. A behavioural model tracks each instance; directed
//   scenarios add targeted checks, followed by randomized traffic.
module tb_prio_arbiter;

    localparam int MH [4] = '{8, 2, 8, 1};
    localparam int RR [4] = '{0, 1, 1, 1};

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] req    = 4'b0000;

    logic [3:0] gnt_a [4];
    logic [1:0] idx_a [4];
    logic       gv_a  [4];
    logic       dn_a  [4];
    logic       bz_a  [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        prio_arbiter #(
            .MAX_HOLD (g == 0 ? 8 : g == 1 ? 2 : g == 2 ? 8 : 1),
            .RR_EN    (g == 0 ? 0 : 1)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .enable    (enable),
            .req       (req),
            .gnt       (gnt_a[g]),
            .gnt_idx   (idx_a[g]),
            .gnt_valid (gv_a[g]),
            .done      (dn_a[g]),
            .busy      (bz_a[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the grant (-1 = nobody), how long it has
    // been held, whether the release gap is showing, and where the next
    // rotating search starts.
    int owner [4] = '{-1, -1, -1, -1};
    int held  [4] = '{0, 0, 0, 0};
    int start [4] = '{0, 0, 0, 0};
    int last  [4] = '{0, 0, 0, 0};
    bit gap   [4] = '{0, 0, 0, 0};

    always @(posedge clock or negedge reset) begin
        for (int k = 0; k < 4; k++) begin
            int o, h, s, l, c;
            bit gp;
            o = owner[k]; h = held[k]; s = start[k]; l = last[k]; gp = gap[k];
            if (!reset) begin
                o = -1; h = 0; s = 0; l = 0; gp = 0;
            end else if (gp) begin
                gp = 0;
            end else if (o >= 0) begin
                if (!req[o] || h == MH[k]) begin
                    gp = 1;
                    s  = (o + 1) % 4;
                    o  = -1;
                end else begin
                    h = h + 1;
                end
            end else if (enable && req != 4'b0000) begin
                for (int j = 0; j < 4; j++) begin
                    c = (RR[k] != 0) ? (s + j) % 4 : j;
                    if (o < 0 && req[c]) begin
                        o = c; l = c; h = 1;
                    end
                end
            end
            owner[k] <= o; held[k] <= h; start[k] <= s; last[k] <= l; gap[k] <= gp;
        end
    end

    logic [3:0] mon_eg;
    always @(negedge clock) begin
        for (int k = 0; k < 4; k++) begin
            mon_eg = (owner[k] >= 0) ? 4'(1 << owner[k]) : 4'b0000;
            check($sformatf("d%0d_gnt", k),   32'(gnt_a[k]), 32'(mon_eg));
            check($sformatf("d%0d_idx", k),   32'(idx_a[k]), 32'(last[k]));
            check($sformatf("d%0d_valid", k), 32'(gv_a[k]),  32'(owner[k] >= 0));
            check($sformatf("d%0d_done", k),  32'(dn_a[k]),  32'(gap[k]));
            check($sformatf("d%0d_busy", k),  32'(bz_a[k]),  32'(owner[k] >= 0 || gap[k]));
        end
    end

    task automatic reset_with(input logic [3:0] r, input logic e);
        @(negedge clock);
        #2 reset = 1'b0;
        req    = r;
        enable = e;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int cnt_g, cnt_d, seen;
        bit found;

        // enable gating
        reset_with(4'b0100, 1'b0);
        repeat (6) begin
            @(negedge clock);
            check("gate_busy", 32'(bz_a[1]), 32'd0);
            check("gate_gnt",  32'(gnt_a[1]), 32'd0);
        end
        enable = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 4; k++) check($sformatf("gate_on_d%0d", k), 32'(gnt_a[k]), 32'h4);

        // fixed priority
        reset_with(4'b1010, 1'b1);
        seen = 0;
        repeat (24) begin
            @(negedge clock);
            if (gv_a[0]) begin
                seen++;
                check("fix_gnt", 32'(gnt_a[0]), 32'h2);
                check("fix_idx", 32'(idx_a[0]), 32'd1);
            end
        end
        check("fix_seen", 32'(seen > 0), 32'd1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            found = (gnt_a[0] == 4'b0010);
        end
        check("fix_found", 32'(found), 32'd1);
        req = 4'b1000;
        @(negedge clock);
        check("fix_drop_done", 32'(dn_a[0]), 32'd1);
        check("fix_drop_gnt",  32'(gnt_a[0]), 32'd0);
        @(negedge clock);
        check("fix_idle_done", 32'(dn_a[0]), 32'd0);
        @(negedge clock);
        check("fix_next_gnt", 32'(gnt_a[0]), 32'h8);
        check("fix_next_idx", 32'(idx_a[0]), 32'd3);

        // rotation with MAX_HOLD=2
        reset_with(4'b1111, 1'b1);
        for (int g = 0; g < 5; g++) begin
            repeat (2) begin
                @(negedge clock);
                check($sformatf("rot%0d_gnt", g),  32'(gnt_a[1]), 32'(1 << (g % 4)));
                check($sformatf("rot%0d_done", g), 32'(dn_a[1]), 32'd0);
            end
            @(negedge clock);
            check($sformatf("rot%0d_gap_gnt", g),  32'(gnt_a[1]), 32'd0);
            check($sformatf("rot%0d_gap_done", g), 32'(dn_a[1]), 32'd1);
            @(negedge clock);
            check($sformatf("rot%0d_idle_gnt", g),  32'(gnt_a[1]), 32'd0);
            check($sformatf("rot%0d_idle_done", g), 32'(dn_a[1]), 32'd0);
        end

        // timeout and request drop on the same edge
        reset_with(4'b0100, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            check($sformatf("to_hold%0d", i), 32'(gnt_a[2]), 32'h4);
        end
        req = 4'b1011;
        @(negedge clock);
        check("to_done",  32'(dn_a[2]), 32'd1);
        check("to_gnt",   32'(gnt_a[2]), 32'd0);
        @(negedge clock);
        check("to_single", 32'(dn_a[2]), 32'd0);
        @(negedge clock);
        check("to_ptr3", 32'(gnt_a[2]), 32'h8);

        // asynchronous reset mid-grant
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ar_d%0d_gnt", k),   32'(gnt_a[k]), 32'd0);
            check($sformatf("ar_d%0d_idx", k),   32'(idx_a[k]), 32'd0);
            check($sformatf("ar_d%0d_valid", k), 32'(gv_a[k]),  32'd0);
            check($sformatf("ar_d%0d_done", k),  32'(dn_a[k]),  32'd0);
            check($sformatf("ar_d%0d_busy", k),  32'(bz_a[k]),  32'd0);
        end
        req = 4'b1111;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 4; k++) check($sformatf("ar_first_d%0d", k), 32'(gnt_a[k]), 32'h1);

        // MAX_HOLD=1
        reset_with(4'b0001, 1'b1);
        cnt_g = 0;
        cnt_d = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            cnt_g += int'(gv_a[3]);
            cnt_d += int'(dn_a[3]);
            check($sformatf("mh1_gnt%0d", i),  32'(gv_a[3]), 32'(i % 3 == 1));
            check($sformatf("mh1_done%0d", i), 32'(dn_a[3]), 32'(i % 3 == 2));
        end
        check("mh1_gnt_cnt",  32'(cnt_g), 32'd4);
        check("mh1_done_cnt", 32'(cnt_d), 32'd4);

        // randomized traffic, checked by the model monitor
        repeat (400) begin
            @(negedge clock);
            if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive cycles one grant is held (legal range 1..15).
REQ-002 Parameter RR_EN, default 1, SHALL select the priority scheme: 1 = rotating, 0 = fixed with index 0 highest.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL gate new grants; 0 blocks arbitration in IDLE.
REQ-006 req  input  4  SHALL carry one request bit per requester; level-sensitive.
REQ-007 gnt  output  4  SHALL be a one-hot grant, or all zero.
REQ-008 gnt_idx  output  2  SHALL give the binary index of the granted requester, valid while gnt_valid=1.
REQ-009 gnt_valid  output  1  SHALL equal the OR of gnt.
REQ-010 done  output  1  SHALL pulse for exactly one cycle per grant release.
REQ-011 busy  output  1  SHALL be 1 whenever state is not IDLE.

Function
REQ-012 All outputs SHALL be registered; no combinational path from req or enable to any output.
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-014 IDLE to GRANT SHALL occur at the edge where enable=1 and req!=0; winner registered into gnt and gnt_idx at that same edge (one-cycle latency from sampled req).
REQ-015 With RR_EN=1, the winner SHALL be the first set req bit searching upward from ptr, wrapping 3->0.
REQ-016 With RR_EN=0, the winner SHALL be the lowest set req bit; ptr is ignored.
REQ-017 hold_cnt SHALL load 1 on entry to GRANT and increment each further GRANT cycle; width 4 bits.
REQ-018 GRANT to GAP SHALL occur at the edge where req[gnt_idx]=0 or hold_cnt==MAX_HOLD; these coinciding SHALL produce one release only.
REQ-019 In GAP, gnt SHALL be 0, gnt_valid 0 and done 1 for exactly one cycle; GAP to IDLE unconditionally.
REQ-020 On release, ptr SHALL update to (gnt_idx+1) mod 4; 3 wraps to 0.
REQ-021 enable falling during GRANT SHALL NOT truncate the current grant.
REQ-022 Requests arriving during GRANT or GAP SHALL be ignored until sampled in IDLE.
REQ-023 MAX_HOLD=1 SHALL give a one-cycle grant; the grant-release-grant cycle is then GRANT, GAP, IDLE (3 cycles).

Reset
REQ-024 reset=0 SHALL immediately force state to IDLE, gnt to 0, gnt_idx to 0, gnt_valid to 0, done to 0, busy to 0, ptr to 0 and hold_cnt to 0, including mid-grant.
REQ-025 After reset deasserts, the first possible grant SHALL be at the first rising edge with reset=1, enable=1 and req!=0.

Structure
REQ-026 Package prio_arbiter_pkg SHALL hold the state encoding (IDLE=0, GRANT=1, GAP=2), N_REQ=4 and IDX_W=2.
REQ-027 The rotating pick SHALL be a combinational sub-module rr_pick (inputs req, ptr, rr_en; outputs idx and any).
REQ-028 ptr, hold_cnt, state and all outputs SHALL reside in prio_arbiter.

Verification
REQ-029 Bench SHALL cover fixed priority: RR_EN=0, req=4'b1010 held -> gnt=4'b0010 and idx=1 on every grant; req[1] dropped -> done after one cycle, then gnt=4'b1000.
REQ-030 Bench SHALL cover rotation: RR_EN=1, req=4'b1111 held, MAX_HOLD=2 -> gnt sequence 0001, 0010, 0100, 1000, 0001, each held 2 cycles, each followed by 1 GAP cycle with done=1.
REQ-031 Bench SHALL cover hold timeout coinciding with req drop: req[2] drops the cycle hold_cnt=8 -> single done pulse and ptr=3.
REQ-032 Bench SHALL cover enable gating: enable=0, req=4'b0100 -> busy=0 and gnt=0 indefinitely; enable=1 -> gnt=4'b0100 after one edge.
REQ-033 Bench SHALL cover reset mid-grant: reset=0 while gnt=4'b1000 -> all outputs 0 without a clock edge; after release with req=4'b1111, first gnt=4'b0001.
REQ-034 Bench SHALL cover MAX_HOLD=1 with req=4'b0001 held -> gnt high 1 cycle in every 3, done high 1 cycle in every 3.
